// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the switch debounce front end.
//   SYNC_STAGES               - depth of the per-channel input synchroniser
//   DEFAULT_DEBOUNCE_CYCLES   - default stable-count length
//   DEFAULT_LONG_PRESS_CYCLES - default hold length for the long-press event
//   clog2()                   - ceiling log2, used to size counters
package debounce_pkg;

  localparam int unsigned SYNC_STAGES               = 2;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = 250000;
  localparam int unsigned DEFAULT_LONG_PRESS_CYCLES = 12500000;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v      = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One switch channel: 2-flop synchroniser, stable-count debouncer, press/release
// pulses, toggle latch and (with DEBOUNCE_LONG_PRESS_EN defined) a long-press
// detector. All outputs are registered.
//   clk_i        - system clock
//   rst_i        - asynchronous active-high reset
//   switch_i     - raw asynchronous switch input, 1 = pressed
//   toggle_clr_i - synchronous clear of toggle_o (wins over a toggle event)
//   level_o      - debounced level
//   press_o      - 1-cycle pulse on debounced 0->1
//   release_o    - 1-cycle pulse on debounced 1->0
//   toggle_o     - toggle state
//   long_o       - 1-cycle long-press pulse (0 when the macro is undefined)
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int unsigned DebounceCycles  = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned ToggleOnRelease = 1,
  parameter int unsigned LongPressCycles = DEFAULT_LONG_PRESS_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic switch_i,
  input  logic toggle_clr_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic toggle_o,
  output logic long_o
);

  localparam int unsigned      CntW   = clog2(DebounceCycles);
  localparam logic [CntW-1:0]  CntMax = CntW'(DebounceCycles - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   toggle_q, toggle_d;
  logic                   sync_s;
  logic                   toggle_evt;
  logic                   toggle_block;

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], switch_i};
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    // Any sample agreeing with the current level restarts the stable count.
    if (sync_s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      level_d   = sync_s;
      cnt_d     = '0;
      press_d   = sync_s;
      release_d = ~sync_s;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end

    toggle_evt = (ToggleOnRelease != 0) ? release_q : press_q;
    if (toggle_clr_i) begin
      toggle_d = 1'b0;
    end else begin
      toggle_d = toggle_q ^ (toggle_evt & ~toggle_block);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      toggle_q  <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
    end
  end

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned      HoldW   = clog2(LongPressCycles + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(LongPressCycles);

  logic [HoldW-1:0] hold_q, hold_d;
  logic             long_q, long_d;

  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (!level_q) begin
      hold_d = '0;
    end else if (hold_q != HoldMax) begin
      hold_d = hold_q + HoldW'(1);
      long_d = (hold_q == HoldMax - HoldW'(1));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  // hold_q only clears the cycle after release_q, so it still shows whether
  // the press that just ended was a long one.
  assign toggle_block = (ToggleOnRelease != 0) && (hold_q == HoldMax);
  assign long_o       = long_q;
`else
  logic unused_long_cfg;
  assign unused_long_cfg = (LongPressCycles != 0);
  assign toggle_block    = 1'b0;
  assign long_o          = 1'b0;
`endif

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign toggle_o  = toggle_q;

endmodule

// File: rtl/debounce_toggle_multi.sv
// N-channel pushbutton front end; each channel is an independent debounce_chan.
// Optional long-press detection is compiled in with DEBOUNCE_LONG_PRESS_EN.
//   i_Clk        - system clock
//   i_Rst        - asynchronous active-high reset
//   i_Switch     - raw switch inputs, 1 = pressed
//   i_Toggle_Clr - synchronous per-channel clear of o_Toggle
//   o_Level      - debounced levels
//   o_Press      - 1-cycle pulses on debounced 0->1
//   o_Release    - 1-cycle pulses on debounced 1->0
//   o_Toggle     - toggle states
//   o_Long       - 1-cycle long-press pulses (0 when compiled out)
module debounce_toggle_multi
  import debounce_pkg::*;
#(
  parameter int unsigned NUM_CH            = 4,
  parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned TOGGLE_ON_RELEASE = 1,
  parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic [NUM_CH-1:0] i_Switch,
  input  logic [NUM_CH-1:0] i_Toggle_Clr,
  output logic [NUM_CH-1:0] o_Level,
  output logic [NUM_CH-1:0] o_Press,
  output logic [NUM_CH-1:0] o_Release,
  output logic [NUM_CH-1:0] o_Toggle,
  output logic [NUM_CH-1:0] o_Long
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    debounce_chan #(
      .DebounceCycles (DEBOUNCE_CYCLES),
      .ToggleOnRelease(TOGGLE_ON_RELEASE),
      .LongPressCycles(LONG_PRESS_CYCLES)
    ) u_chan (
      .clk_i       (i_Clk),
      .rst_i       (i_Rst),
      .switch_i    (i_Switch[g]),
      .toggle_clr_i(i_Toggle_Clr[g]),
      .level_o     (o_Level[g]),
      .press_o     (o_Press[g]),
      .release_o   (o_Release[g]),
      .toggle_o    (o_Toggle[g]),
      .long_o      (o_Long[g])
    );
  end

endmodule

// File: tb/tb_debounce_toggle_multi.sv
module tb_debounce_toggle_multi;

  localparam int NCH = 2;
  localparam int DC  = 4;
  localparam int LP  = 10;
  localparam int TOR = 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] sw  = '0;
  logic [NCH-1:0] clr = '0;
  logic [NCH-1:0] lvl, prs, rel, tog, lng;

  debounce_toggle_multi #(
    .NUM_CH           (NCH),
    .DEBOUNCE_CYCLES  (DC),
    .TOGGLE_ON_RELEASE(TOR),
    .LONG_PRESS_CYCLES(LP)
  ) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_Switch    (sw),
    .i_Toggle_Clr(clr),
    .o_Level     (lvl),
    .o_Press     (prs),
    .o_Release   (rel),
    .o_Toggle    (tog),
    .o_Long      (lng)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: outputs expected after each edge.
  logic [NCH-1:0] m_lvl = '0, m_prs = '0, m_rel = '0, m_tog = '0, m_long = '0;
  logic [31:0]    rawh[NCH];   // raw input samples, bit0 = most recent edge
  logic [31:0]    presh[NCH];  // synchronised samples seen by the debouncer
  int             since[NCH];  // edges since reset or last level change
  int             held[NCH];   // edges the level has been 1
  bit             long_seen[NCH];

  int prs_cnt[NCH], rel_cnt[NCH], long_cnt[NCH];
  int prs_t[NCH], rel_t[NCH], long_t[NCH];

  task automatic model_step();
    if (rst) begin
      m_lvl = '0; m_prs = '0; m_rel = '0; m_tog = '0; m_long = '0;
      for (int c = 0; c < NCH; c++) begin
        rawh[c] = '0; presh[c] = '0; since[c] = 0; held[c] = 0; long_seen[c] = 0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        bit ev, s, flip;
        ev = (TOR != 0) ? m_rel[c] : m_prs[c];
`ifdef DEBOUNCE_LONG_PRESS_EN
        if ((TOR != 0) && long_seen[c]) ev = 1'b0;
        m_long[c] = 1'b0;
        if (m_lvl[c]) begin
          if (held[c] < LP) begin
            held[c]++;
            if (held[c] == LP) begin
              m_long[c]    = 1'b1;
              long_seen[c] = 1'b1;
            end
          end
        end else begin
          held[c] = 0;
        end
`endif
        m_tog[c] = clr[c] ? 1'b0 : (m_tog[c] ^ ev);
        // Synchronised value is the raw sample from two edges ago.
        s        = rawh[c][1];
        rawh[c]  = {rawh[c][30:0], sw[c]};
        presh[c] = {presh[c][30:0], s};
        if (since[c] < 1000) since[c]++;
        // Level changes once DC consecutive samples all disagree with it.
        flip = (since[c] >= DC);
        for (int i = 0; i < DC; i++) if (presh[c][i] == m_lvl[c]) flip = 1'b0;
        m_prs[c] = 1'b0;
        m_rel[c] = 1'b0;
        if (flip) begin
          m_lvl[c] = s;
          m_prs[c] = s;
          m_rel[c] = ~s;
          since[c] = 0;
          if (s) long_seen[c] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) begin
      rawh[c] = '0; presh[c] = '0; since[c] = 0; held[c] = 0; long_seen[c] = 0;
      prs_cnt[c] = 0; rel_cnt[c] = 0; long_cnt[c] = 0;
      prs_t[c] = 0; rel_t[c] = 0; long_t[c] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
    end
  end

  // Per-cycle comparison against the model plus pulse bookkeeping.
  initial begin
    logic [5*NCH-1:0] got, exp;
    forever begin
      @(negedge clk);
      got = {lvl, prs, rel, tog, lng};
      exp = rst ? '0 : {m_lvl, m_prs, m_rel, m_tog, m_long};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL model_cmp cyc=%0d got(lvl,prs,rel,tog,long)=%b required=%b",
                 cyc, got, exp);
      end
      if (!rst) begin
        for (int c = 0; c < NCH; c++) begin
          if (prs[c]) begin prs_cnt[c]++; prs_t[c] = cyc; end
          if (rel[c]) begin rel_cnt[c]++; rel_t[c] = cyc; end
          if (lng[c]) begin long_cnt[c]++; long_t[c] = cyc; end
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Edges until the chosen output bit of channel 0 is seen high; -1 on timeout.
  task automatic edges_until(input bit use_rel, output int n_out);
    n_out = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if ((use_rel ? rel[0] : lvl[0]) === 1'b1) begin
        n_out = n;
        break;
      end
    end
  endtask

  initial begin
    int lat, p0, l1, t1, rem[NCH];

    // Reset state
    repeat (3) tick();
    check("reset_outputs", int'({lvl, prs, rel, tog, lng}), 0);
    rst = 1'b0;
    tick();

    // Reset mid-count, then latency from first sampled 1
    sw = 2'b11;
    repeat (4) tick();
    rst = 1'b1;
    repeat (3) tick();
    check("reset_midcount_outputs", int'({lvl, prs, rel, tog, lng}), 0);
    rst = 1'b0;
    edges_until(1'b0, lat);
    check("reset_release_latency", lat, 6);
    check("reset_release_level", int'(lvl), 3);

    // Release both (toggles both), then clear
    tick();
    sw = 2'b00;
    repeat (12) tick();
    check("release_toggle_both", int'(tog), 3);
    clr = 2'b11;
    tick();
    clr = 2'b00;
    tick();
    check("clear_both", int'(tog), 0);

    // Bounce on ch0: 3 high, 1 low, then high
    p0 = prs_cnt[0];
    sw[0] = 1'b1;
    repeat (3) tick();
    sw[0] = 1'b0;
    tick();
    sw[0] = 1'b1;
    edges_until(1'b0, lat);
    check("bounce_latency", lat, 6);
    tick();
    check("bounce_single_press", prs_cnt[0] - p0, 1);
    sw[0] = 1'b0;
    repeat (12) tick();
    check("bounce_release_toggle", int'(tog[0]), 1);

    // Clean press/release toggle timing on ch0
    clr = 2'b01;
    tick();
    clr = 2'b00;
    tick();
    sw[0] = 1'b1;
    repeat (7) tick();
    sw[0] = 1'b0;
    edges_until(1'b1, lat);
    check("toggle_release_seen", int'(lat > 0), 1);
    check("toggle_release_no_press", int'(prs[0]), 0);
    check("toggle_before_flip", int'(tog[0]), 0);
    @(posedge clk);
    #1;
    check("toggle_after_flip", int'(tog[0]), 1);
    check("release_one_cycle", int'(rel[0]), 0);
    tick();
    sw[0] = 1'b1;
    repeat (7) tick();
    sw[0] = 1'b0;
    repeat (12) tick();
    check("toggle_repeat", int'(tog[0]), 0);

    // Clear on ch0 in the flip cycle; ch1 toggles normally
    sw = 2'b11;
    repeat (7) tick();
    sw = 2'b00;
    edges_until(1'b1, lat);
    check("clr_release_seen", int'(lat > 0), 1);
    clr = 2'b01;
    @(posedge clk);
    #1;
    clr = 2'b00;
    check("clear_beats_toggle", int'(tog), 2);
    tick();

    // Independence: 2-cycle offset
    sw[0] = 1'b1;
    tick();
    tick();
    sw[1] = 1'b1;
    repeat (12) tick();
    check("indep_press_offset", prs_t[1] - prs_t[0], 2);
    check("indep_levels", int'(lvl), 3);
    sw[0] = 1'b0;
    tick();
    tick();
    sw[1] = 1'b0;
    repeat (12) tick();
    check("indep_release_offset", rel_t[1] - rel_t[0], 2);

    // Long press on ch1
    l1 = long_cnt[1];
    t1 = int'(tog[1]);
    sw[1] = 1'b1;
    repeat (20) begin
      tick();
      if (lvl[1]) break;
    end
    repeat (20) tick();
    sw[1] = 1'b0;
    repeat (12) tick();
`ifdef DEBOUNCE_LONG_PRESS_EN
    check("long_pulse_count", long_cnt[1] - l1, 1);
    check("long_after_press", long_t[1] - prs_t[1], 10);
    check("long_release_no_toggle", int'(tog[1]), t1);
`else
    check("long_absent", long_cnt[1] - l1, 0);
    check("long_off_toggles", int'(tog[1]), 1 - t1);
`endif

    // Randomised phase
    for (int c = 0; c < NCH; c++) rem[c] = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) rst = 1'b1;
      if (i == 2003) rst = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        if (rem[c] == 0) begin
          sw[c]  = 1'($urandom_range(0, 1));
          rem[c] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(12, 30))
                                                : int'($urandom_range(1, 8));
        end
        rem[c]--;
        clr[c] = ($urandom_range(0, 15) == 0);
      end
      tick();
    end
    clr = '0;
    sw  = '0;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debounce_toggle_multi.md
Name: debounce_toggle_multi

Overview:
- Parametrised N-channel switch front end: per channel, a 2-flop input synchroniser, then a stable-count debouncer, then edge pulses and a toggle latch.
- Generalises the single-switch, fixed-count, toggle-on-release block to: configurable channel count, debounce length and toggle edge; a synchronous toggle clear; glitch rejection (counter restarts on any bounce).
- Sits between board pushbuttons and LED/user logic. All outputs registered.

Parameters:
- NUM_CH, 4, number of independent switch channels (1..16).
- DEBOUNCE_CYCLES, 250000, consecutive cycles a synchronised input must differ from the debounced level before that level changes (>=2).
- TOGGLE_ON_RELEASE, 1, 1: toggle on the debounced 1->0 edge; 0: toggle on the debounced 0->1 edge.
- LONG_PRESS_CYCLES, 12500000, hold length for the long-press event (used only with the optional feature).

Ports:
- i_Clk, input, 1, system clock.
- i_Rst, input, 1, asynchronous active-high reset.
- i_Switch, input, NUM_CH, raw asynchronous switch inputs; 1 = pressed.
- i_Toggle_Clr, input, NUM_CH, synchronous per-channel clear of o_Toggle.
- o_Level, output, NUM_CH, debounced switch level.
- o_Press, output, NUM_CH, 1-cycle pulse on the debounced 0->1 edge.
- o_Release, output, NUM_CH, 1-cycle pulse on the debounced 1->0 edge.
- o_Toggle, output, NUM_CH, toggle state (drives LEDs).
- o_Long, output, NUM_CH, 1-cycle long-press pulse; constant 0 when the feature is compiled out.

Behaviour:
- Reset (async, i_Rst=1): synchroniser flops, o_Level, o_Press, o_Release, o_Toggle, o_Long, all counters and all flags go to 0 immediately. Logic resumes on the first i_Clk edge after deassertion.
- Synchroniser: 2 flops per channel. s_Sync = i_Switch delayed 2 cycles.
- Counter width: $clog2(DEBOUNCE_CYCLES). Counter is one per channel, independent.
- Each cycle, per channel:
  - If s_Sync == o_Level: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: o_Level <= s_Sync, counter <= 0, and the matching pulse fires (o_Press if the new level is 1, o_Release if 0).
  - Else: counter <= counter+1.
- Latency: a clean input step produces the o_Level change DEBOUNCE_CYCLES+2 edges after i_Switch changes (2 synchroniser + DEBOUNCE_CYCLES).
- Glitches: any input pulse shorter than DEBOUNCE_CYCLES cycles at s_Sync is ignored. A single-cycle return to the old level restarts the count from 0.
- o_Press / o_Release:
  - Asserted for exactly 1 cycle, in the same cycle o_Level updates.
  - Never both high on one channel.
  - Deasserted otherwise.
- o_Toggle: inverts on the cycle after the selected pulse. Pulse selection: o_Release if TOGGLE_ON_RELEASE=1, o_Press if 0.
- i_Toggle_Clr: o_Toggle <= 0 next edge. Clear wins over a simultaneous toggle event.
- Channels never interact. Simultaneous events on different channels are all honoured in the same cycle.
- No counter wrap: the counter saturates at DEBOUNCE_CYCLES-1 by construction.

Optional Feature:
- Macro: DEBOUNCE_LONG_PRESS_EN.
- Defined:
  - Per-channel hold counter, width $clog2(LONG_PRESS_CYCLES+1). It counts while o_Level=1 and clears when o_Level=0.
  - When it reaches LONG_PRESS_CYCLES, o_Long pulses 1 cycle and the counter holds; at most one pulse per press.
  - With TOGGLE_ON_RELEASE=1, the release that ends a long press does not toggle (o_Release still pulses).
- Not defined: hold counter absent, o_Long tied 0, toggling unaffected.

Decomposition:
- Package debounce_pkg holds:
  - function clog2 helper;
  - localparam-default constants DEFAULT_DEBOUNCE_CYCLES=250000 and DEFAULT_LONG_PRESS_CYCLES=12500000;
  - constant SYNC_STAGES=2.
- One sub-module, debounce_chan: synchroniser, counter, level, pulses, toggle and optional long-press logic for one channel.
- Top level generate-instantiates NUM_CH copies.

Test Plan (bench uses NUM_CH=2, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10, TOGGLE_ON_RELEASE=1):
- Reset: hold i_Rst mid-count with i_Switch=2'b11 -> all outputs 0 while asserted. After release, o_Level[0]=1 exactly 6 edges after first sampled 1.
- Bounce: on ch0 drive 1 for 3 cycles, 0 for 1, 1 for 4 -> single o_Press pulse, none from the 3-cycle burst. o_Level rises 6 edges after the final 1 starts.
- Toggle: press then release ch0 cleanly -> o_Press, then o_Release 1 cycle each. o_Toggle[0] goes 0->1 one cycle after o_Release. A repeat returns it to 0.
- Clear vs toggle: assert i_Toggle_Clr[0] in the cycle o_Toggle would flip -> o_Toggle[0]=0. Ch1 toggling in the same cycle is unaffected.
- Independence: step both channels with 2-cycle offset -> pulses 2 cycles apart, counts uncorrupted.
- Long press (DEBOUNCE_LONG_PRESS_EN):
  - Hold ch1 for 20 cycles after o_Level=1 -> one o_Long pulse 10 cycles after o_Press.
  - Release -> o_Release pulses and o_Toggle[1] is unchanged.
  - Without the macro, o_Long stays 0 and toggling behaves as a normal press.
